moldudp64_hdr_tx: RTL and testbench
===================================

# moldudp64_hdr_tx

- Transmit-side MoldUDP64 header serializer.
- Latches a session ID, sequence number and message count in host (little-endian) order on a start handshake.
- Emits the 20-byte header in network (big-endian) byte order as three beats on a 64-bit valid/ready stream, with byte lane 0 (`data_o[7:0]`) first on the wire.
- Sits in front of the message payload path; it is the transmit counterpart of the receive-side header parser and its byte-order conversion.

## Interface

Parameters:
- None. Widths are fixed by the MoldUDP64 header format.

Ports (all synchronous to `clk`; one clock; reset is asynchronous and active-low):
- `clk`  in  1  — clock
- `nreset`  in  1  — asynchronous, active-low reset
- `start_i`  in  1  — request to send one header
- `ready_o`  out  1  — block can accept `start_i`
- `sid_i`  in  80  — session ID, host order; `[7:0]` is the least significant byte
- `seq_i`  in  64  — sequence number, host order
- `cnt_i`  in  16  — message count, host order
- `valid_o`  out  1  — output beat valid
- `ready_i`  in  1  — downstream accepts the beat
- `data_o`  out  64  — beat data; lane k is `data_o[8k+7:8k]`, and lane 0 is first on the wire
- `keep_o`  out  8  — lane enables, one bit per byte
- `last_o`  out  1  — final header beat

## Operation

- FSM states: IDLE, B0, B1, B2.
- `ready_o` = (state == IDLE). This is a pure state decode, with no combinational path from `ready_i`.
- Start accept = `start_i & ready_o`:
  - Latches `sid_i`/`seq_i`/`cnt_i` into internal registers after conversion to big-endian.
  - Next state is B0.
- `start_i` is ignored when `ready_o` = 0.
- Beat handshake = `valid_o & ready_i`:
  - B0 → B1 → B2 on each handshake.
  - B2 → IDLE on its handshake.
  - Without a handshake the state holds.
- Wire byte order: SID[9..0], then SEQ[7..0], then CNT[1..0], most significant byte first.
- B0:
  - Lanes 0–7 = SID bytes 9..2.
  - `keep_o` = 8'hFF, `last_o` = 0.
- B1:
  - Lanes 0–1 = SID bytes 1..0; lanes 2–7 = SEQ bytes 7..2.
  - `keep_o` = 8'hFF, `last_o` = 0.
- B2:
  - Lanes 0–1 = SEQ bytes 1..0; lanes 2–3 = CNT bytes 1..0; lanes 4–7 = 0.
  - `keep_o` = 8'h0F, `last_o` = 1.
- In IDLE: `valid_o` = 0; `data_o`, `keep_o` and `last_o` = 0.
- Field values get no special treatment. `cnt_i` = 0 (heartbeat) and 16'hFFFF (end of session) serialize like any other value.

## Timing

- Reset values: state = IDLE, `ready_o` = 1, `valid_o` = 0, `data_o` = 0, `keep_o` = 0, `last_o` = 0, latched fields = 0.
- All outputs are registered or pure state decodes.
- Latency: start accepted in cycle N → B0 valid in cycle N+1.
- With `ready_i` held at 1:
  - Beats appear in cycles N+1, N+2, N+3.
  - IDLE (`ready_o` = 1) is reached in N+4.
  - Minimum header period is 4 cycles, with one idle bubble.
- Backpressure: while `valid_o & ~ready_i`, `data_o`, `keep_o` and `last_o` hold stable and `valid_o` stays 1.
- Input fields are sampled only at start accept. Later changes to `sid_i`/`seq_i`/`cnt_i` do not affect the header in flight.
- Reset asserted mid-header:
  - All outputs go to their reset values immediately (asynchronous).
  - The partial header is abandoned, with no `last_o`.
  - After release, the first accepted start produces a complete header.

## Structure

- Shared package (`moldudp64_pkg`) holds:
  - `SID_W` = 80, `SEQ_W` = 64, `CNT_W` = 16, `HDR_BYTES` = 20.
  - The state enum (IDLE/B0/B1/B2).
  - `KEEP_LAST` = 8'h0F.
- Sub-module: reuse `endian_flip`, three instances:
  - B=10 for SID, B=8 for SEQ, B=2 for CNT.
  - Each converts at the latch input.
- Beat muxing is a case on state over the concatenated 160-bit big-endian header vector, zero-padded to 192 bits.

## Test plan

- Basic header:
  - Stimulus: `sid_i` = 80'h00010203040506070809, `seq_i` = 64'h1011121314151617, `cnt_i` = 16'h0203, `ready_i` = 1.
  - Response: `data_o` = 64'h0706050403020100 (keep FF), then 64'h1514131211100908 (keep FF), then 64'h0000000003021716 (keep 0F, `last_o` = 1).
- Backpressure:
  - Stimulus: same fields; `ready_i` = 0 for 3 cycles during B1.
  - Response: B1 data stable, `valid_o` = 1 throughout, then B2 follows; beat sequence is identical to the basic header.
- Input change after accept:
  - Stimulus: change `seq_i` to 0 the cycle after start accept.
  - Response: the header still carries 64'h1011121314151617.
- Start while busy:
  - Stimulus: pulse `start_i` during B1 with a different SID.
  - Response: ignored; exactly 3 beats; `ready_o` returns to 1 four cycles after the original start.
- Reset mid-header:
  - Stimulus: assert `nreset` during B1.
  - Response: `valid_o` = 0 immediately, with no `last_o`.
  - Then: after release, a header with `cnt_i` = 16'hFFFF ends with B2 `data_o[31:16]` = 16'hFFFF, keep 0F.
- Back-to-back:
  - Stimulus: `start_i` held at 1, `ready_i` = 1.
  - Response: starts accepted every 4 cycles; `last_o` pulses every 4th cycle.

Source files
------------

// File: rtl/moldudp64_pkg.sv
// moldudp64_pkg: shared MoldUDP64 header widths, FSM state type and lane constants.
package moldudp64_pkg;
    localparam int SID_W     = 80;
    localparam int SEQ_W     = 64;
    localparam int CNT_W     = 16;
    localparam int HDR_BYTES = 20;
    localparam logic [7:0] KEEP_LAST = 8'h0F;
    typedef enum logic [1:0] {IDLE, B0, B1, B2} hdr_state_t;
endpackage

// File: rtl/endian_flip.sv
// endian_flip: reverses the byte order of a B-byte word (host <-> network order).
module endian_flip #(
    parameter int B = 2
) (
    input  logic [8*B-1:0] i_data,
    output logic [8*B-1:0] o_data
);
    for (genvar i = 0; i < B; i++) begin : g_byte
        assign o_data[8*i +: 8] = i_data[8*(B-1-i) +: 8];
    end
endmodule

// File: rtl/moldudp64_hdr_tx.sv
// moldudp64_hdr_tx: latches a MoldUDP64 header on start and streams it big-endian as three 64-bit beats.
module moldudp64_hdr_tx
    import moldudp64_pkg::*;
(
    input  logic             clk,
    input  logic             nreset,
    input  logic             start_i,
    output logic             ready_o,
    input  logic [SID_W-1:0] sid_i,
    input  logic [SEQ_W-1:0] seq_i,
    input  logic [CNT_W-1:0] cnt_i,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [63:0]      data_o,
    output logic [7:0]       keep_o,
    output logic             last_o
);
    hdr_state_t r_state, w_next;
    logic [SID_W-1:0] r_sid, w_sid_be;
    logic [SEQ_W-1:0] r_seq, w_seq_be;
    logic [CNT_W-1:0] r_cnt, w_cnt_be;
    logic [8*HDR_BYTES-1:0] w_hdr;
    logic [191:0] w_hdr_pad;
    logic w_accept;

    endian_flip #(.B(10)) u_sid (.i_data(sid_i), .o_data(w_sid_be));
    endian_flip #(.B(8))  u_seq (.i_data(seq_i), .o_data(w_seq_be));
    endian_flip #(.B(2))  u_cnt (.i_data(cnt_i), .o_data(w_cnt_be));

    // wire byte i sits at bits [8i+7:8i], so beat k is simply slice k of the padded vector
    assign w_hdr     = {r_cnt, r_seq, r_sid};
    assign w_hdr_pad = {32'd0, w_hdr};
    assign ready_o   = r_state == IDLE;
    assign valid_o   = ~ready_o;
    assign w_accept  = start_i & ready_o;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= IDLE;
            r_sid   <= '0;
            r_seq   <= '0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_sid <= w_sid_be;
                r_seq <= w_seq_be;
                r_cnt <= w_cnt_be;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        data_o = '0;
        keep_o = '0;
        last_o = 1'b0;
        case (r_state)
            IDLE: w_next = start_i ? B0 : IDLE;
            B0: begin
                w_next = ready_i ? B1 : B0;
                data_o = w_hdr_pad[63:0];
                keep_o = 8'hFF;
            end
            B1: begin
                w_next = ready_i ? B2 : B1;
                data_o = w_hdr_pad[127:64];
                keep_o = 8'hFF;
            end
            B2: begin
                w_next = ready_i ? IDLE : B2;
                data_o = w_hdr_pad[191:128];
                keep_o = KEEP_LAST;
                last_o = 1'b1;
            end
        endcase
    end
endmodule

// File: tb/tb_moldudp64_hdr_tx.sv
// tb_moldudp64_hdr_tx: directed stimulus checked against a byte-list header model every cycle.
module tb_moldudp64_hdr_tx;
    logic clk = 1'b0, nreset = 1'b0, start_i = 1'b0, ready_i = 1'b1;
    logic [79:0] sid_i = '0;
    logic [63:0] seq_i = '0;
    logic [15:0] cnt_i = '0;
    logic ready_o, valid_o, last_o;
    logic [63:0] data_o;
    logic [7:0] keep_o;
    int checks = 0, errors = 0;

    localparam logic [79:0] SID_A = 80'h00010203040506070809;
    localparam logic [63:0] SEQ_A = 64'h1011121314151617;
    localparam logic [15:0] CNT_A = 16'h0203;
    localparam logic [63:0] E0 = 64'h0706050403020100;
    localparam logic [63:0] E1 = 64'h1514131211100908;
    localparam logic [63:0] E2 = 64'h0000000003021716;

    moldudp64_hdr_tx dut (
        .clk(clk), .nreset(nreset), .start_i(start_i), .ready_o(ready_o),
        .sid_i(sid_i), .seq_i(seq_i), .cnt_i(cnt_i), .valid_o(valid_o),
        .ready_i(ready_i), .data_o(data_o), .keep_o(keep_o), .last_o(last_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: the header is a list of 20 wire bytes; beat k carries bytes 8k..8k+7
    logic        m_busy;
    int          m_beat;
    logic [7:0]  m_bytes [20];

    always @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            m_busy <= 1'b0;
            m_beat <= 0;
        end else if (!m_busy) begin
            if (start_i) begin
                m_busy <= 1'b1;
                m_beat <= 0;
                for (int i = 0; i < 10; i++) m_bytes[i] <= sid_i[8*(9-i) +: 8];
                for (int i = 0; i < 8; i++) m_bytes[10+i] <= seq_i[8*(7-i) +: 8];
                m_bytes[18] <= cnt_i[15:8];
                m_bytes[19] <= cnt_i[7:0];
            end
        end else if (ready_i) begin
            if (m_beat == 2) m_busy <= 1'b0;
            m_beat <= m_beat + 1;
        end
    end

    function automatic logic [63:0] exp_data();
        logic [63:0] d = '0;
        if (m_busy)
            for (int l = 0; l < 8; l++)
                if (8*m_beat + l < 20) d[8*l +: 8] = m_bytes[8*m_beat + l];
        return d;
    endfunction

    function automatic logic [7:0] exp_keep();
        logic [7:0] k = '0;
        if (m_busy)
            for (int l = 0; l < 8; l++) k[l] = (8*m_beat + l < 20);
        return k;
    endfunction

    always @(negedge clk) begin
        chk("m_ready", ready_o, !m_busy);
        chk("m_valid", valid_o, m_busy);
        chk("m_data", data_o, exp_data());
        chk("m_keep", keep_o, exp_keep());
        chk("m_last", last_o, m_busy && 8*(m_beat+1) >= 20);
    end

    task automatic start_hdr(input logic [79:0] s, input logic [63:0] q, input logic [15:0] c);
        @(posedge clk); #1;
        sid_i = s; seq_i = q; cnt_i = c; start_i = 1'b1;
        @(posedge clk); #1;
        start_i = 1'b0;
    endtask

    task automatic get_beat(output logic [63:0] d, output logic [7:0] k, output logic l, output int n);
        n = 0;
        @(negedge clk);
        while (!(valid_o && ready_i) && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL beat_timeout: no beat after %0d cycles", n);
        end
        d = data_o; k = keep_o; l = last_o;
    endtask

    task automatic hdr_lits(input string nm, input logic [63:0] e0, input logic [63:0] e1, input logic [63:0] e2);
        logic [63:0] d; logic [7:0] k; logic l; int n;
        get_beat(d, k, l, n);
        chk({nm, "_lat"}, n, 0);
        chk({nm, "_d0"}, d, e0); chk({nm, "_k0"}, k, 8'hFF); chk({nm, "_l0"}, l, 0);
        get_beat(d, k, l, n);
        chk({nm, "_d1"}, d, e1); chk({nm, "_k1"}, k, 8'hFF); chk({nm, "_l1"}, l, 0);
        get_beat(d, k, l, n);
        chk({nm, "_d2"}, d, e2); chk({nm, "_k2"}, k, 8'h0F); chk({nm, "_l2"}, l, 1);
    endtask

    initial begin
        logic [63:0] d; logic [7:0] k; logic l; int n;
        #2;
        chk("rst_ready", ready_o, 1); chk("rst_valid", valid_o, 0);
        chk("rst_data", data_o, 0); chk("rst_keep", keep_o, 0); chk("rst_last", last_o, 0);
        repeat (2) @(negedge clk);
        nreset = 1'b1;

        start_hdr(SID_A, SEQ_A, CNT_A);
        hdr_lits("basic", E0, E1, E2);

        start_hdr(SID_A, SEQ_A, CNT_A);
        get_beat(d, k, l, n);
        chk("bp_d0", d, E0);
        @(posedge clk); #1;
        ready_i = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("bp_valid", valid_o, 1); chk("bp_hold", data_o, E1);
            chk("bp_keep", keep_o, 8'hFF); chk("bp_last", last_o, 0);
            @(posedge clk);
        end
        #1 ready_i = 1'b1;
        get_beat(d, k, l, n);
        chk("bp_d1", d, E1); chk("bp_n1", n, 0);
        get_beat(d, k, l, n);
        chk("bp_d2", d, E2); chk("bp_l2", l, 1);

        start_hdr(SID_A, SEQ_A, CNT_A);
        seq_i = '0;
        hdr_lits("chg", E0, E1, E2);

        start_hdr(SID_A, SEQ_A, CNT_A);
        get_beat(d, k, l, n);
        @(posedge clk); #1;
        start_i = 1'b1; sid_i = 80'hAAAA_BBBB_CCCC_DDDD_EEEE;
        get_beat(d, k, l, n);
        chk("busy_d1", d, E1);
        get_beat(d, k, l, n);
        start_i = 1'b0;
        chk("busy_d2", d, E2);
        @(negedge clk);
        chk("busy_ready4", ready_o, 1);
        repeat (3) begin
            @(negedge clk);
            chk("busy_no4th", valid_o, 0);
        end

        start_hdr(SID_A, SEQ_A, CNT_A);
        get_beat(d, k, l, n);
        @(posedge clk); #2;
        nreset = 1'b0;
        #1;
        chk("mid_valid", valid_o, 0); chk("mid_last", last_o, 0);
        chk("mid_data", data_o, 0); chk("mid_ready", ready_o, 1);
        repeat (2) @(negedge clk);
        nreset = 1'b1;
        start_hdr(SID_A, SEQ_A, 16'hFFFF);
        hdr_lits("eos", E0, E1, 64'h00000000FFFF1716);

        @(posedge clk); #1;
        start_i = 1'b1; sid_i = SID_A; seq_i = SEQ_A; cnt_i = 16'h0000;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("b2b_last", last_o, i % 4 == 3);
            chk("b2b_ready", ready_o, i % 4 == 0);
        end
        start_i = 1'b0;
        repeat (3) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
